// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared types and widths for the instruction fetch stage
package mips_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - shift-style instruction buffer with flush and registered head
module instr_fifo
    import mips_fetch_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    output logic [CNT_W-1:0]   count,
    output logic               head_valid,
    output logic [INSTR_W-1:0] head_instr,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [ADDR_W-1:0]  head_pcplus4
);

    fetch_entry_t      mem     [BUF_DEPTH];
    fetch_entry_t      nxt_mem [BUF_DEPTH];
    logic [CNT_W-1:0]  nxt_count;
    logic [CNT_W-1:0]  wr_idx;
    logic              do_pop;
    logic              do_push;
    logic [ADDR_W-1:0] pcplus4_q;

    // Entry 0 is always the head, so the head outputs come straight from flops.
    always_comb begin
        nxt_mem   = mem;
        nxt_count = count;
        do_pop    = pop && (count != '0);
        wr_idx    = count - CNT_W'(do_pop);
        do_push   = push && (wr_idx < CNT_W'(BUF_DEPTH));
        if (flush) begin
            nxt_count = '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < BUF_DEPTH - 1; i++) begin
                    nxt_mem[i] = mem[i+1];
                end
            end
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (do_push && (wr_idx == CNT_W'(i))) begin
                    nxt_mem[i] = push_data;
                end
            end
            nxt_count = count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            pcplus4_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            count     <= nxt_count;
            mem       <= nxt_mem;
            pcplus4_q <= nxt_mem[0].pc + ADDR_W'(4);
        end
    end

    assign head_valid   = (count != '0);
    assign head_instr   = mem[0].instr;
    assign head_pc      = mem[0].pc;
    assign head_pcplus4 = pcplus4_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and imem request FSM; FETCH_PERF_CNT_EN adds perf counters
module fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  pcplus4,
    output logic               instr_valid,
    input  logic               instr_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_t      state, next_state;
    logic [ADDR_W-1:0] fetch_pc, next_pc;
    logic [CNT_W-1:0]  count;
    logic              outstanding;
    logic              push;
    logic              discard;
    fetch_entry_t      push_data;

    assign outstanding = (state != REQ);
    // Reserve a buffer slot for every request so a response can always be stored.
    assign imem_req  = !reset && (state == REQ) &&
                       (({1'b0, count} + (CNT_W+1)'(outstanding)) < (CNT_W+1)'(BUF_DEPTH));
    assign imem_addr = fetch_pc;

    always_comb begin
        next_state = state;
        next_pc    = fetch_pc;
        push       = 1'b0;
        discard    = 1'b0;
        case (state)
            REQ: begin
                if (imem_req && imem_ready) begin
                    next_pc    = fetch_pc + ADDR_W'(4);
                    next_state = redirect ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push       = !redirect;
                    discard    = redirect;
                    next_state = REQ;
                end else if (redirect) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    discard    = 1'b1;
                    next_state = REQ;
                end
            end
            default: next_state = REQ;
        endcase
        if (redirect) begin
            next_pc = redirect_pc & ~ADDR_W'(3);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= REQ;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= next_state;
            fetch_pc <= next_pc;
        end
    end

    // In WAIT fetch_pc already points past the outstanding request.
    assign push_data.instr = imem_rdata;
    assign push_data.pc    = fetch_pc - ADDR_W'(4);

    instr_fifo #(
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_W     (CNT_W)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .flush        (redirect),
        .push         (push),
        .push_data    (push_data),
        .pop          (instr_ready),
        .count        (count),
        .head_valid   (instr_valid),
        .head_instr   (instr),
        .head_pc      (instr_pc),
        .head_pcplus4 (pcplus4)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (!instr_valid && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (discard && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven bench for fetch_unit plus wrap-around sequence
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ready, imem_rvalid, redirect, instr_ready;
    logic [31:0] imem_rdata, redirect_pc;

    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, instr_pc, pcplus4;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc, w_p4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, w_stall, w_flush;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pcplus4     (pcplus4),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (w_instr),
        .instr_pc    (w_pc),
        .pcplus4     (w_p4),
        .instr_valid (w_valid),
        .instr_ready (instr_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt (w_stall),
        .perf_flush_cnt (w_flush)
`endif
    );

    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] rdata;
        logic        rd;
        logic [31:0] rpc;
        logic        ird;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr, e_pc, e_p4;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] iw(input logic [31:0] pc);
        return 32'h1100_0000 + pc;
    endfunction

    task automatic add(input logic rst, rdy, rv, input logic [31:0] rdata,
                       input logic rd, input logic [31:0] rpc, input logic ird,
                       input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                       input logic [31:0] e_instr, e_pc, e_p4);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
        v.rd = rd; v.rpc = rpc; v.ird = ird;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_p4 = e_p4;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, rdy, rv, input logic [31:0] rdata,
                         input logic rd, input logic [31:0] rpc, input logic ird);
        reset = rst; imem_ready = rdy; imem_rvalid = rv; imem_rdata = rdata;
        redirect = rd; redirect_pc = rpc; instr_ready = ird;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);

        //   rst rdy rv rdata          rd rpc          ird  req addr          iv instr          pc            p4
        add(1, 0, 0, 0,             0, 0,            0,   0, 32'h0,        0, 0,             0,            0);
        add(1, 0, 0, 0,             0, 0,            0,   0, 32'h0,        0, 0,             32'h0,        32'h0);
        add(0, 1, 0, 0,             0, 0,            1,   1, 32'h0,        0, 0,             0,            0);
        add(0, 1, 1, iw(32'h0),     0, 0,            1,   0, 32'h4,        0, 0,             0,            0);
        add(0, 1, 0, 0,             0, 0,            1,   1, 32'h4,        1, iw(32'h0),     32'h0,        32'h4);
        add(0, 1, 1, iw(32'h4),     0, 0,            1,   0, 32'h8,        0, 0,             0,            0);
        add(0, 1, 0, 0,             0, 0,            1,   1, 32'h8,        1, iw(32'h4),     32'h4,        32'h8);
        add(0, 1, 1, iw(32'h8),     0, 0,            1,   0, 32'hC,        0, 0,             0,            0);
        add(0, 1, 0, 0,             0, 0,            1,   1, 32'hC,        1, iw(32'h8),     32'h8,        32'hC);
        add(0, 1, 1, iw(32'hC),     0, 0,            1,   0, 32'h10,       0, 0,             0,            0);
        add(0, 1, 0, 0,             0, 0,            0,   1, 32'h10,       1, iw(32'hC),     32'hC,        32'h10);
        add(0, 1, 1, iw(32'h10),    0, 0,            0,   0, 32'h14,       1, iw(32'hC),     32'hC,        32'h10);
        add(0, 1, 0, 0,             0, 0,            0,   0, 32'h14,       1, iw(32'hC),     32'hC,        32'h10);
        add(0, 1, 0, 0,             0, 0,            1,   0, 32'h14,       1, iw(32'hC),     32'hC,        32'h10);
        add(0, 1, 0, 0,             0, 0,            1,   1, 32'h14,       1, iw(32'h10),    32'h10,       32'h14);
        add(0, 0, 0, 0,             1, 32'h43,       1,   0, 32'h18,       0, 0,             0,            0);
        add(0, 0, 1, 32'hDEAD_BEEF, 0, 0,            1,   0, 32'h40,       0, 0,             0,            0);
        add(0, 1, 0, 0,             0, 0,            1,   1, 32'h40,       0, 0,             0,            0);
        add(0, 0, 1, iw(32'h40),    1, 32'h80,       1,   0, 32'h44,       0, 0,             0,            0);
        add(0, 1, 0, 0,             0, 0,            1,   1, 32'h80,       0, 0,             0,            0);
        add(0, 0, 1, iw(32'h80),    0, 0,            1,   0, 32'h84,       0, 0,             0,            0);
        add(0, 0, 0, 0,             0, 0,            1,   1, 32'h84,       1, iw(32'h80),    32'h80,       32'h84);
        add(0, 1, 0, 0,             1, 32'h200,      1,   1, 32'h84,       0, 0,             0,            0);
        add(0, 0, 1, 32'h0BAD_0BAD, 0, 0,            1,   0, 32'h200,      0, 0,             0,            0);
        add(0, 1, 0, 0,             0, 0,            0,   1, 32'h200,      0, 0,             0,            0);
        add(0, 0, 1, iw(32'h200),   0, 0,            0,   0, 32'h204,      0, 0,             0,            0);
        add(0, 1, 0, 0,             0, 0,            0,   1, 32'h204,      1, iw(32'h200),   32'h200,      32'h204);
        add(0, 0, 1, iw(32'h204),   0, 0,            1,   0, 32'h208,      1, iw(32'h200),   32'h200,      32'h204);
        add(0, 0, 0, 0,             0, 0,            0,   1, 32'h208,      1, iw(32'h204),   32'h204,      32'h208);
        add(0, 1, 0, 0,             0, 0,            0,   1, 32'h208,      1, iw(32'h204),   32'h204,      32'h208);
        add(1, 0, 0, 0,             0, 0,            0,   0, 32'h20C,      1, iw(32'h204),   32'h204,      32'h208);
        add(0, 0, 1, 32'h0EEE_0EEE, 0, 0,            0,   1, 32'h0,        0, 0,             0,            0);
        add(0, 0, 0, 0,             0, 0,            0,   1, 32'h0,        0, 0,             0,            0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rdata,
                  tbl[i].rd, tbl[i].rpc, tbl[i].ird);
            #1;
            if (i > 0) begin
                check($sformatf("row%0d imem_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
                check($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].e_addr);
                check($sformatf("row%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].e_iv});
                if (tbl[i].e_iv || tbl[i].rst) begin
                    check($sformatf("row%0d instr", i), instr, tbl[i].e_instr);
                    check($sformatf("row%0d instr_pc", i), instr_pc, tbl[i].e_pc);
                    check($sformatf("row%0d pcplus4", i), pcplus4, tbl[i].e_p4);
                end
            end
`ifdef FETCH_PERF_CNT_EN
            if (i == 2)  check("perf_stall after reset", perf_stall_cnt, 32'd0);
            if (i == 4)  check("perf_stall streaming", perf_stall_cnt, 32'd2);
            if (i == 29) check("perf_flush discards", perf_flush_cnt, 32'd3);
            if (i == 31) check("perf_flush after reset", perf_flush_cnt, 32'd0);
`endif
        end

        // Address wrap: second instance starts at the top of the address space.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 0, 1);
        #1;
        check("wrap first req", {31'b0, w_req}, 32'd1);
        check("wrap first addr", w_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        drive(0, 0, 1, 32'hCAFE_F00D, 0, 0, 1);
        #1;
        check("wrap pc rolled", w_addr, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("wrap valid", {31'b0, w_valid}, 32'd1);
        check("wrap instr", w_instr, 32'hCAFE_F00D);
        check("wrap instr_pc", w_pc, 32'hFFFF_FFFC);
        check("wrap pcplus4", w_p4, 32'h0);
        check("wrap second req", {31'b0, w_req}, 32'd1);
        check("wrap second addr", w_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
